song_sequencer: RTL
===================

// Module: song_sequencer
// PURPOSE
//  Player-side counterpart of the MCU control interface. Consumes play/rewind/ff/reset_player/song.
//  Walks the selected song's notes in the note ROM and hands each note to the note player.
//  Pulses song_done at end of song, which the MCU uses to advance to the next song.
// PARAMETERS
//  SONG_W  2  song select width (number of songs = 2**SONG_W)
//  IDX_W   5  note index width; a song holds 2**IDX_W notes; LAST = 2**IDX_W-1
//  NOTE_W  6  note code width
//  DUR_W   6  duration field width
//  SKIP    4  number of notes jumped per rewind/ff pulse
// PORTS
//  clk           in   1               system clock
//  reset         in   1               asynchronous, active-low reset
//  play          in   1               1 = advance through notes; 0 = frozen (pause)
//  rewind        in   1               1-cycle pulse: jump back SKIP notes
//  ff            in   1               1-cycle pulse: jump forward SKIP notes
//  reset_player  in   1               synchronous restart of the current song at note 0
//  song          in   SONG_W          selected song
//  rom_addr      out  SONG_W+IDX_W    = {song, idx}, combinational from registered idx
//  rom_data      in   NOTE_W+DUR_W    {note, duration}; registered ROM, valid 1 cycle after addr
//  note          out  NOTE_W          latched note code for the player
//  duration      out  DUR_W           latched duration for the player
//  new_note      out  1               1-cycle strobe: note/duration are valid, start playing
//  note_done     in   1               player finished current note (only sampled in WAIT_NOTE)
//  song_done     out  1               1-cycle pulse: last note finished or ff past the end
// BEHAVIOUR
//  Reset (reset=0, async): state=FETCH, idx=0, note=0, duration=0, new_note=0, song_done=0.
//  States:
//  - FETCH: ROM latency cycle. If play=1, go to ISSUE next cycle; otherwise hold.
//  - ISSUE: latch rom_data into note/duration, assert new_note for exactly this cycle, then WAIT_NOTE.
//  - WAIT_NOTE: on note_done=1 go to NEXT; if play=0, hold (note_done is still honoured).
//  - NEXT: if idx==LAST, go to DONE; else idx<=idx+1, then FETCH.
//  - DONE: song_done=1 for one cycle, then HOLD.
//  - HOLD: idle, all strobes 0, until reset_player.
//  Priority each cycle: reset_player > rewind > ff > normal FSM.
//  - reset_player: idx<=0, state<=FETCH, new_note=0, song_done=0; valid in every state.
//  - rewind: idx <= (idx<SKIP) ? 0 : idx-SKIP (saturate at 0), then FETCH. Same cycle as ff: rewind wins.
//  - ff: if idx+SKIP > LAST (compute at IDX_W+1 bits, no wrap), go to DONE; else idx+=SKIP, then FETCH.
//  - rewind/ff in HOLD: ignored.
//  Interrupting a note: rewind/ff abort the note being played; next new_note comes 2 cycles later.
//  Latency: idx change -> new_note asserted 2 cycles later (FETCH, ISSUE), provided play=1.
//  song change without reset_player: takes effect at the next FETCH; the MCU always pulses reset_player.
//  idx never wraps.
// CONFIGURATION
//  END_MARKER_EN
//  - Defined: a ROM word that is all zeros (note=0 AND duration=0) seen in ISSUE is end-of-song.
//    No new_note is issued; go directly to DONE. ff to such a slot behaves the same way.
//  - Undefined: all-zero words play as rests of length 0.
//    End-of-song occurs only after note index LAST.
// STRUCTURE
//  Shared package (music_pkg):
//  - state encodings: SEQ_FETCH, SEQ_ISSUE, SEQ_WAIT, SEQ_NEXT, SEQ_DONE, SEQ_HOLD
//  - NOTE_W, DUR_W, SONG_W defaults
//  Sub-module: seq_index_ctr holds idx.
//  - load 0, +1, -SKIP saturating, +SKIP with overflow flag
//  - built on dffr/dffre
//  FSM state register: dffr with async active-low clear.
// TESTING
//  1. Reset low mid-ISSUE -> new_note, song_done, idx all 0 immediately; on release, FETCH and rom_addr={song,0}.
//  2. song=2, play=1, ROM idx0={5,10} -> rom_addr=7'h40; new_note pulses once, 2 cycles later,
//     with note=5, duration=10; idx1 fetched after note_done.
//  3. idx=2, rewind pulse -> idx=0 (saturated), new_note 2 cycles later.
//     idx=9, rewind -> idx=5. Rewind+ff same cycle -> rewind applied.
//  4. idx=29, ff pulse -> song_done 1-cycle pulse, then HOLD.
//     reset_player in the same cycle as song_done -> FETCH with idx=0.
//  5. play=0 during WAIT_NOTE with note_done=1 -> NEXT taken, but no new_note until play=1.
//     After that, new_note follows 1 cycle after play rises.
//  6. END_MARKER_EN defined, ROM idx3=0 -> no new_note for idx3; song_done 1 cycle after ISSUE.
//     Undefined -> new_note with note=0, duration=0.

Source files
------------

// File: rtl/music_pkg.sv
// Shared sequencer definitions: FSM state encodings and default field widths.
package music_pkg;
    localparam int SONG_W = 2;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    typedef enum logic [2:0] {
        SEQ_FETCH = 3'd0,
        SEQ_ISSUE = 3'd1,
        SEQ_WAIT  = 3'd2,
        SEQ_NEXT  = 3'd3,
        SEQ_DONE  = 3'd4,
        SEQ_HOLD  = 3'd5
    } seq_state_t;
endpackage

// File: rtl/seq_index_ctr.sv
// Note index counter for the song sequencer, plus the flop primitives it is built on.
module dffr #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_q <= '0;
        else          o_q <= i_d;
    end
endmodule

module dffre #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  o_q <= '0;
        else if (i_en) o_q <= i_d;
    end
endmodule

module seq_index_ctr #(
    parameter int IDX_W = 5,
    parameter int SKIP  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_rew,
    input  logic             i_ff,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_ff_ovf
);
    localparam logic [IDX_W:0]   LAST_X = {1'b0, {IDX_W{1'b1}}};
    localparam logic [IDX_W:0]   SKIP_X = (IDX_W+1)'(SKIP);
    localparam logic [IDX_W-1:0] SKIP_I = IDX_W'(SKIP);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_en;

    // Forward jump is evaluated one bit wider so running past the end never wraps.
    assign w_sum    = {1'b0, o_idx} + SKIP_X;
    assign o_ff_ovf = (w_sum > LAST_X);
    assign w_en     = i_clr | i_rew | i_ff | i_inc;

    always_comb begin
        w_idx_next = o_idx;
        if (i_clr)
            w_idx_next = '0;
        else if (i_rew)
            w_idx_next = ({1'b0, o_idx} < SKIP_X) ? '0 : o_idx - SKIP_I;
        else if (i_ff)
            w_idx_next = w_sum[IDX_W-1:0];
        else if (i_inc)
            w_idx_next = o_idx + 1'b1;
    end

    dffre #(.W(IDX_W)) u_idx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_en),
        .i_d     (w_idx_next),
        .o_q     (o_idx)
    );
endmodule

// File: rtl/song_sequencer.sv
// Walks the selected song in the note ROM and hands notes to the player.
// Build option END_MARKER_EN: an all-zero ROM word ends the song instead of playing.
module song_sequencer #(
    parameter int SONG_W = music_pkg::SONG_W,
    parameter int IDX_W  = 5,
    parameter int NOTE_W = music_pkg::NOTE_W,
    parameter int DUR_W  = music_pkg::DUR_W,
    parameter int SKIP   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_play,
    input  logic                    i_rewind,
    input  logic                    i_ff,
    input  logic                    i_reset_player,
    input  logic [SONG_W-1:0]       i_song,
    output logic [SONG_W+IDX_W-1:0] o_rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] i_rom_data,
    output logic [NOTE_W-1:0]       o_note,
    output logic [DUR_W-1:0]        o_duration,
    output logic                    o_new_note,
    input  logic                    i_note_done,
    output logic                    o_song_done
);
    import music_pkg::*;

    localparam logic [IDX_W-1:0] LAST = '1;

    logic [2:0]              w_state_bits;
    seq_state_t              w_state;
    seq_state_t              w_state_next;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_ff_ovf;
    logic                    w_idx_clr;
    logic                    w_idx_inc;
    logic                    w_idx_rew;
    logic                    w_idx_ff;
    logic                    w_new_note;
    logic                    w_is_end;
    logic [NOTE_W+DUR_W-1:0] w_held;

`ifdef END_MARKER_EN
    assign w_is_end = (i_rom_data == '0);
`else
    assign w_is_end = 1'b0;
`endif

    dffr #(.W(3)) u_state (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_state_next),
        .o_q     (w_state_bits)
    );
    assign w_state = seq_state_t'(w_state_bits);

    seq_index_ctr #(.IDX_W(IDX_W), .SKIP(SKIP)) u_idx (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_idx_clr),
        .i_inc    (w_idx_inc),
        .i_rew    (w_idx_rew),
        .i_ff     (w_idx_ff),
        .o_idx    (w_idx),
        .o_ff_ovf (w_ff_ovf)
    );

    // Transport controls override the note walk; a jump aborts whatever is playing.
    always_comb begin
        w_state_next = w_state;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
        w_idx_rew    = 1'b0;
        w_idx_ff     = 1'b0;
        w_new_note   = 1'b0;
        if (i_reset_player) begin
            w_idx_clr    = 1'b1;
            w_state_next = SEQ_FETCH;
        end else if (i_rewind && (w_state != SEQ_HOLD)) begin
            w_idx_rew    = 1'b1;
            w_state_next = SEQ_FETCH;
        end else if (i_ff && (w_state != SEQ_HOLD)) begin
            if (w_ff_ovf) begin
                w_state_next = SEQ_DONE;
            end else begin
                w_idx_ff     = 1'b1;
                w_state_next = SEQ_FETCH;
            end
        end else begin
            case (w_state)
                SEQ_FETCH: if (i_play) w_state_next = SEQ_ISSUE;
                SEQ_ISSUE: begin
                    if (w_is_end) begin
                        w_state_next = SEQ_DONE;
                    end else begin
                        w_new_note   = 1'b1;
                        w_state_next = SEQ_WAIT;
                    end
                end
                SEQ_WAIT:  if (i_note_done) w_state_next = SEQ_NEXT;
                SEQ_NEXT: begin
                    if (w_idx == LAST) begin
                        w_state_next = SEQ_DONE;
                    end else begin
                        w_idx_inc    = 1'b1;
                        w_state_next = SEQ_FETCH;
                    end
                end
                SEQ_DONE:  w_state_next = SEQ_HOLD;
                SEQ_HOLD:  w_state_next = SEQ_HOLD;
                default:   w_state_next = SEQ_FETCH;
            endcase
        end
    end

    // The ROM word is forwarded during the strobe and held afterwards.
    dffre #(.W(NOTE_W+DUR_W)) u_note (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_new_note),
        .i_d     (i_rom_data),
        .o_q     (w_held)
    );

    assign {o_note, o_duration} = w_new_note ? i_rom_data : w_held;
    assign o_new_note  = w_new_note;
    assign o_song_done = (w_state == SEQ_DONE);
    assign o_rom_addr  = {i_song, w_idx};
endmodule
